// File: rtl/dmem_responder.sv
// Handshaked load/store responder over an internal little-endian word array.
// One request in flight at a time; the response appears LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int DMEM_DEPTH = 256,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         IDX_W    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DMEM_DEPTH] = '{default: 32'h0};

    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [2:0]       cur_func3;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_word;
    logic             enter_resp;
    logic             mem_we;
    logic [3:0]       wmask;
    logic [31:0]      wlane;

    function automatic logic access_err(input logic wr, input logic [31:0] addr,
                                        input logic [2:0] func3);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        case (func3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = wr;
            default:                illegal = 1'b1;
        endcase
        misaligned   = ((func3[1:0] == 2'b01) && addr[0]) ||
                       ((func3 == 3'b010) && (addr[1:0] != 2'b00));
        out_of_range = (addr[31:2] >= 30'(DMEM_DEPTH));
        return illegal | misaligned | out_of_range;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] func3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (func3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] lane, input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // With LATENCY=1 the access happens on the accept edge, so use the live request in IDLE
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_func3 = func3_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_func3 = req_func3;
            cur_wdata = req_wdata;
        end
    end

    assign cur_err    = access_err(cur_write, cur_addr, cur_func3);
    assign cur_idx    = cur_addr[IDX_W+1:2];
    assign cur_word   = mem_q[cur_idx];
    assign enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));
    assign wmask      = store_mask(cur_addr[1:0], cur_func3);
    assign wlane      = store_lanes(cur_wdata, cur_func3);
    assign mem_we     = enter_resp && cur_write && !cur_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if ((state_q == IDLE) && req_valid) begin
            write_d = req_write;
            addr_d  = req_addr;
            func3_d = req_func3;
            wdata_d = req_wdata;
            cnt_d   = CNT_INIT;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_write || cur_err) ? 32'h0 : load_ext(cur_word, cur_addr[1:0], cur_func3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        write_q <= write_d;
        addr_q  <= addr_d;
        func3_q <= func3_d;
        wdata_q <= wdata_d;
    end

    // Array has no reset: a store committed before reset stays committed
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[cur_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 at LATENCY=2, instance 1 at LATENCY=1,
// checked against a byte-addressed reference model.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [2:0]  req_func3 [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;
    rsp_t exp_q0[$];
    rsp_t exp_q1[$];
    byte unsigned mb [2][DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DMEM_DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_func3(req_func3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DMEM_DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_func3(req_func3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte image, loads assembled and sign-adjusted arithmetically
    task automatic model_access(input int sel, input bit wr, input logic [31:0] a,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
        int size;
        bit sgn;
        bit legal;
        longint unsigned av;
        longint unsigned v;
        size  = 4;
        sgn   = 1'b0;
        legal = 1'b1;
        av    = 64'(a);
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    begin size = 1; legal = !wr; end
            3'd5:    begin size = 2; legal = !wr; end
            default: legal = 1'b0;
        endcase
        er = !legal || ((av % 64'(size)) != 0) || ((av / 4) >= 64'(DEPTH));
        rd = 32'h0;
        if (!er && wr) begin
            for (int i = 0; i < size; i++) mb[sel][int'(av) + i] = 8'(wd >> (8 * i));
        end else if (!er) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (64'(mb[sel][int'(av) + i]) << (8 * i));
            if (sgn && (v >= (64'd1 << (8 * size - 1))))
                v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
            rd = v[31:0];
        end
    endtask

    task automatic mon_pop(input int s);
        rsp_t e;
        bit have;
        have = 1'b0;
        e    = '0;
        if (s == 0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            have = 1'b1;
        end else if (s == 1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected inst%0d rdata=%h err=%b expected=none", s, rsp_rdata[s], rsp_err[s]);
        end else begin
            chk($sformatf("rsp_rdata_inst%0d", s), rsp_rdata[s], e.rdata);
            chk($sformatf("rsp_err_inst%0d", s), 32'(rsp_err[s]), 32'(e.err));
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rsp_valid[s] === 1'b1 && rsp_ready[s] === 1'b1) mon_pop(s);
        end
    end

    task automatic do_req(input int sel, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold, input bit use_exp,
                          input logic [31:0] xr, input bit xe);
        rsp_t e;
        logic [31:0] mr;
        bit me;
        int n;
        logic [31:0] r0;
        logic e0;
        model_access(sel, wr, a, f3, wd, mr, me);
        e.rdata = use_exp ? xr : mr;
        e.err   = use_exp ? xe : me;
        if (sel == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        req_write[sel] = wr;
        req_addr[sel]  = a;
        req_func3[sel] = f3;
        req_wdata[sel] = wd;
        req_valid[sel] = 1'b1;
        n = 0;
        while (req_ready[sel] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);
        @(posedge clk); #1;
        // Request lines carry junk after acceptance; the responder must ignore them
        req_write[sel] = 1'($urandom_range(0, 1));
        req_addr[sel]  = $urandom;
        req_func3[sel] = 3'($urandom);
        req_wdata[sel] = $urandom;
        n = 0;
        while (rsp_valid[sel] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat_of(sel) - 1));
        r0 = rsp_rdata[sel];
        e0 = rsp_err[sel];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid[sel]), 32'd1);
            chk("hold_rdata", rsp_rdata[sel], r0);
            chk("hold_err", 32'(rsp_err[sel]), 32'(e0));
            chk("hold_req_ready", 32'(req_ready[sel]), 32'd0);
        end
        req_valid[sel] = 1'b0;
        rsp_ready[sel] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[sel] = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid[sel]), 32'd0);
        chk("done_req_ready", 32'(req_ready[sel]), 32'd1);
    endtask

    task automatic directed(input int sel);
        do_req(sel, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 1, 32'h0, 0);
        do_req(sel, 0, 32'h10, 3'd2, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        do_req(sel, 1, 32'h10, 3'd2, 32'h80FF7F01, 0, 1, 32'h0, 0);
        do_req(sel, 0, 32'h13, 3'd0, 32'h0, 0, 1, 32'hFFFFFF80, 0);
        do_req(sel, 0, 32'h13, 3'd4, 32'h0, 0, 1, 32'h00000080, 0);
        do_req(sel, 0, 32'h12, 3'd1, 32'h0, 0, 1, 32'hFFFF80FF, 0);
        do_req(sel, 0, 32'h10, 3'd5, 32'h0, 0, 1, 32'h00007F01, 0);
        do_req(sel, 0, 32'h10, 3'd0, 32'h0, 0, 1, 32'h00000001, 0);
        do_req(sel, 1, 32'h11, 3'd0, 32'h000000AA, 0, 1, 32'h0, 0);
        do_req(sel, 0, 32'h10, 3'd2, 32'h0, 0, 1, 32'h80FFAA01, 0);
        do_req(sel, 1, 32'h12, 3'd1, 32'h00001234, 0, 1, 32'h0, 0);
        do_req(sel, 0, 32'h10, 3'd2, 32'h0, 5, 1, 32'h1234AA01, 0);
        do_req(sel, 1, 32'h20, 3'd2, 32'hCAFEF00D, 0, 1, 32'h0, 0);
        do_req(sel, 0, 32'h12, 3'd2, 32'h0, 0, 1, 32'h0, 1);
        do_req(sel, 1, 32'h21, 3'd1, 32'h0000BEEF, 2, 1, 32'h0, 1);
        do_req(sel, 0, 32'h20, 3'd2, 32'h0, 0, 1, 32'hCAFEF00D, 0);
        do_req(sel, 0, 32'(DEPTH * 4), 3'd2, 32'h0, 0, 1, 32'h0, 1);
        do_req(sel, 0, 32'h10, 3'd3, 32'h0, 0, 1, 32'h0, 1);
        do_req(sel, 1, 32'h10, 3'd4, 32'h55555555, 0, 1, 32'h0, 1);
        do_req(sel, 0, 32'h10, 3'd2, 32'h0, 0, 1, 32'h1234AA01, 0);
    endtask

    task automatic reset_midop(input int sel);
        logic [31:0] rd;
        bit er;
        req_write[sel] = 1'b1;
        req_addr[sel]  = 32'h30;
        req_func3[sel] = 3'd2;
        req_wdata[sel] = 32'h11111111;
        req_valid[sel] = 1'b1;
        chk("midop_req_ready", 32'(req_ready[sel]), 32'd1);
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
        reset[sel]     = 1'b1;
        @(posedge clk); #1;
        reset[sel] = 1'b0;
        chk("midop_rsp_valid", 32'(rsp_valid[sel]), 32'd0);
        chk("midop_req_ready_after", 32'(req_ready[sel]), 32'd1);
        // The immediate-RESP path has already committed the store when reset arrives
        if (lat_of(sel) == 1) model_access(sel, 1, 32'h30, 3'd2, 32'h11111111, rd, er);
        do_req(sel, 0, 32'h30, 3'd2, 32'h0, 0, 1,
               (lat_of(sel) == 1) ? 32'h11111111 : 32'h0, 0);
    endtask

    task automatic random_run(input int sel, input int count);
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            a = 32'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            do_req(sel, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 3)), 0, 32'h0, 0);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            reset[s]     = 1'b1;
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_addr[s]  = 32'h0;
            req_func3[s] = 3'd0;
            req_wdata[s] = 32'h0;
            rsp_ready[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) reset[s] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_req_ready_inst%0d", s), 32'(req_ready[s]), 32'd1);
            chk($sformatf("reset_rsp_valid_inst%0d", s), 32'(rsp_valid[s]), 32'd0);
            chk($sformatf("reset_rsp_rdata_inst%0d", s), rsp_rdata[s], 32'h0);
            chk($sformatf("reset_rsp_err_inst%0d", s), 32'(rsp_err[s]), 32'd0);
        end
        for (int s = 0; s < 2; s++) begin
            directed(s);
            reset_midop(s);
            random_run(s, 150);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
        chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
